// File: rtl/decoder_pkg.sv
// Shared decode types for the integer multiply/divide path.
package decoder_pkg;

  // Legacy multiplier-only encoding; md_op_t covers it and adds the divides.
  typedef enum logic [1:0] {
    MUL_LO    = 2'b00,
    MUL_HI_SS = 2'b01,
    MUL_HI_SU = 2'b10,
    MUL_HI_UU = 2'b11
  } mul_op_t;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } md_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the iterative multiplier/divider: BITS_PER_CYCLE shift-add
// (LSB-first multiply) or restoring-subtract (MSB-first divide) steps.
module muldiv_step #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] mcand,
  output logic [XLEN-1:0] acc_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN-1:0] acc, lo;
  logic [XLEN:0]   r, diff;

  always_comb begin
    acc  = acc_i;
    lo   = lo_i;
    r    = '0;
    diff = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (is_div) begin
        // remainder stays below the divisor, so r < 2*divisor fits XLEN+1
        r    = {acc, lo[XLEN-1]};
        diff = r - {1'b0, mcand};
        lo   = {lo[XLEN-2:0], ~diff[XLEN]};
        acc  = diff[XLEN] ? r[XLEN-1:0] : diff[XLEN-1:0];
      end else begin
        r    = {1'b0, acc} + (lo[0] ? {1'b0, mcand} : '0);
        lo   = {r[0], lo[XLEN-1:1]};
        acc  = r[XLEN:1];
      end
    end
    acc_o = acc;
    lo_o  = lo;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit. Operands are reduced to
// magnitudes at accept; the sign is restored once when the result is captured.
module muldiv_unit
  import decoder_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  md_op_t          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            abort,
  output logic            ready,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  md_state_t       state, state_n;
  logic [CW-1:0]   cnt;
  md_op_t          op_q;
  logic            neg_q;
  logic [XLEN-1:0] acc, lo, mcand, acc_n, lo_n;
  logic            accept, bypass, last, div_zero, ovf, a_sgn, b_sgn, neg;
  logic [XLEN-1:0] a_mag, b_mag, bypass_res, final_res, prod_hi;

  muldiv_step #(.XLEN(XLEN), .BITS_PER_CYCLE(BITS_PER_CYCLE)) u_step (
    .is_div (op_q[2]),
    .acc_i  (acc),
    .lo_i   (lo),
    .mcand  (mcand),
    .acc_o  (acc_n),
    .lo_o   (lo_n)
  );

  always_comb begin
    a_sgn    = (op == MD_MULH || op == MD_MULHSU || op == MD_DIV || op == MD_REM) && a[XLEN-1];
    b_sgn    = (op == MD_MULH || op == MD_DIV || op == MD_REM) && b[XLEN-1];
    a_mag    = a_sgn ? -a : a;
    b_mag    = b_sgn ? -b : b;
    neg      = (op == MD_REM) ? a_sgn : (a_sgn ^ b_sgn);
    div_zero = op[2] && (b == '0);
    ovf      = (op == MD_DIV || op == MD_REM) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    bypass   = div_zero || ovf;
    if (div_zero) bypass_res = op[1] ? a : '1;
    else          bypass_res = op[1] ? '0 : a;
  end

  // Two's-complement negate of the 2*XLEN product, high half only.
  always_comb begin
    prod_hi = neg_q ? (~acc_n + XLEN'(lo_n == '0)) : acc_n;
    case (op_q)
      MD_MUL:                        final_res = lo_n;
      MD_MULH, MD_MULHSU, MD_MULHU:  final_res = prod_hi;
      MD_DIV, MD_DIVU:               final_res = neg_q ? -lo_n : lo_n;
      default:                       final_res = neg_q ? -acc_n : acc_n;
    endcase
  end

  always_comb begin
    state_n = state;
    ready   = (state != CALC);
    valid   = (state == DONE);
    accept  = start && ready && !abort;
    last    = (cnt == LAST);
    if (abort) state_n = IDLE;
    else begin
      case (state)
        IDLE, DONE: state_n = accept ? (bypass ? DONE : CALC) : IDLE;
        CALC:       if (last) state_n = DONE;
        default:    state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      op_q   <= MD_MUL;
      neg_q  <= 1'b0;
      acc    <= '0;
      lo     <= '0;
      mcand  <= '0;
      result <= '0;
    end else if (abort) begin
      cnt <= '0;
    end else if (accept) begin
      cnt   <= '0;
      op_q  <= op;
      neg_q <= neg;
      if (bypass) result <= bypass_res;
      else begin
        acc   <= '0;
        lo    <= op[2] ? a_mag : b_mag;
        mcand <= op[2] ? b_mag : a_mag;
      end
    end else if (state == CALC) begin
      acc <= acc_n;
      lo  <= lo_n;
      cnt <= last ? '0 : cnt + CW'(1);
      if (last) result <= final_res;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus handshake/abort/reset sequences.
module tb_muldiv_unit;
  import decoder_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start1, start4, abort;
  md_op_t      op;
  logic [31:0] a, b;
  logic        ready1, valid1, ready4, valid4;
  logic [31:0] result1, result4;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .op(op), .a(a), .b(b), .abort(abort),
    .ready(ready1), .valid(valid1), .result(result1)
  );

  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .op(op), .a(a), .b(b), .abort(abort),
    .ready(ready4), .valid(valid4), .result(result4)
  );

  typedef struct {
    md_op_t      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Accept at the posedge after drive; latency 1 means valid already high just after that edge.
  task automatic issue(input bit w4, input md_op_t o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] r, output int lat);
    @(negedge clk);
    op = o; a = x; b = y;
    if (w4) start4 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start4 = 1'b0;
    lat = 1;
    while (!(w4 ? valid4 : valid1) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    r = w4 ? result4 : result1;
  endtask

  task automatic no_valid_window(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (valid1) seen++;
    end
    check(name, seen, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int lat;

    vecs[0]  = '{MD_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33};
    vecs[1]  = '{MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[2]  = '{MD_MUL,    32'd6,        32'd7,        32'd42,       33};
    vecs[3]  = '{MD_MUL,    32'd0,        32'd12345,    32'd0,        33};
    vecs[4]  = '{MD_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33};
    vecs[5]  = '{MD_MUL,    32'h12345678, 32'h10,       32'h23456780, 33};
    vecs[6]  = '{MD_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    vecs[7]  = '{MD_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    vecs[8]  = '{MD_DIVU,   32'd100,      32'd7,        32'd14,       33};
    vecs[9]  = '{MD_REMU,   32'd100,      32'd7,        32'd2,        33};
    vecs[10] = '{MD_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33};
    vecs[11] = '{MD_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        33};
    vecs[12] = '{MD_DIVU,   32'h1234,     32'd0,        32'hFFFFFFFF, 1};
    vecs[13] = '{MD_REMU,   32'h1234,     32'd0,        32'h1234,     1};
    vecs[14] = '{MD_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[15] = '{MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
    vecs[16] = '{MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[17] = '{MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33};

    reset = 1'b1; start1 = 1'b0; start4 = 1'b0; abort = 1'b0;
    op = MD_MUL; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_ready", {31'd0, ready1}, 1);
    check("reset_valid", {31'd0, valid1}, 0);
    check("reset_result", result1, 0);
    check("reset_ready4", {31'd0, ready4}, 1);

    for (int i = 0; i < 18; i++) begin
      issue(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, r, lat);
      check($sformatf("vec%0d_result", i), r, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
    end

    issue(1'b1, MD_MULHSU, 32'h80000000, 32'd2, r, lat);
    check("bpc4_mulhsu_result", r, 32'hFFFFFFFF);
    check("bpc4_mulhsu_latency", lat, 9);
    issue(1'b1, MD_DIV, 32'hFFFFFFF9, 32'd2, r, lat);
    check("bpc4_div_result", r, 32'hFFFFFFFD);
    check("bpc4_div_latency", lat, 9);
    issue(1'b1, MD_REMU, 32'd100, 32'd7, r, lat);
    check("bpc4_remu_result", r, 32'd2);

    // start held high across CALC and DONE: ignored in CALC, re-accepted in DONE
    @(negedge clk);
    op = MD_MUL; a = 32'd6; b = 32'd7; start1 = 1'b1;
    @(posedge clk); #1;
    op = MD_DIVU; a = 32'd100; b = 32'd7;
    lat = 1;
    while (!valid1 && lat < 200) begin @(posedge clk); #1; lat++; end
    check("b2b_first_latency", lat, 33);
    check("b2b_first_result", result1, 42);
    check("b2b_ready_in_done", {31'd0, ready1}, 1);
    @(posedge clk); #1;
    start1 = 1'b0;
    check("b2b_ready_low", {31'd0, ready1}, 0);
    check("b2b_valid_low", {31'd0, valid1}, 0);
    lat = 1;
    while (!valid1 && lat < 200) begin @(posedge clk); #1; lat++; end
    check("b2b_second_latency", lat, 33);
    check("b2b_second_result", result1, 14);

    // abort at iteration 10 keeps the previous result
    @(negedge clk);
    op = MD_DIVU; a = 32'd100; b = 32'd7; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_ready", {31'd0, ready1}, 1);
    check("abort_valid", {31'd0, valid1}, 0);
    check("abort_result", result1, 14);
    no_valid_window("abort_no_valid", 40);

    // abort wins over start in the same cycle
    @(negedge clk);
    op = MD_MUL; a = 32'd3; b = 32'd3; start1 = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; abort = 1'b0;
    check("abort_vs_start_ready", {31'd0, ready1}, 1);
    no_valid_window("abort_vs_start_no_valid", 40);

    // reset mid-CALC wins over abort and start
    @(negedge clk);
    op = MD_MUL; a = 32'd6; b = 32'd7; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); reset = 1'b1; abort = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; abort = 1'b0; start1 = 1'b0;
    check("rst_mid_ready", {31'd0, ready1}, 1);
    check("rst_mid_valid", {31'd0, valid1}, 0);
    check("rst_mid_result", result1, 0);
    no_valid_window("rst_mid_no_valid", 40);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand/result width, even, >= 8.
REQ-002 SHALL have parameter BITS_PER_CYCLE, default 1: quotient/multiplier bits retired per iteration, legal 1/2/4, XLEN divisible by it.
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous active-high reset.
REQ-005 SHALL have port start  in  1  request; accepted when start && ready.
REQ-006 SHALL have port op  in  3  md_op_t operation, RISC-V M funct3 encoding.
REQ-007 SHALL have ports a, b  in  XLEN  rs1/rs2 operands, sampled only at accept.
REQ-008 SHALL have port abort  in  1  flush; discards any operation in flight.
REQ-009 SHALL have port ready  out  1  unit can accept a request this cycle.
REQ-010 SHALL have port valid  out  1  one-cycle pulse, result valid.
REQ-011 SHALL have port result  out  XLEN  result, held stable until next accept.

Function
REQ-012 SHALL implement FSM IDLE, CALC, DONE; ready=1 in IDLE and DONE, 0 in CALC.
REQ-013 Accept in IDLE/DONE SHALL latch op/a/b, go to CALC; valid=0 next cycle.
REQ-014 CALC SHALL run exactly XLEN/BITS_PER_CYCLE cycles (iteration counter, wraps to 0), then DONE.
REQ-015 DONE SHALL assert valid for one cycle; next state IDLE, or CALC if a new start is accepted that cycle (back-to-back).
REQ-016 Normal latency, accept edge to valid: XLEN/BITS_PER_CYCLE+1 cycles (33 at defaults).
REQ-017 MUL SHALL return low XLEN bits of a*b; MULH high XLEN bits signed*signed; MULHSU signed a * unsigned b; MULHU unsigned*unsigned.
REQ-018 DIV/REM SHALL be signed, truncating toward zero, remainder sign = dividend sign; DIVU/REMU unsigned.
REQ-019 Divide by zero SHALL bypass CALC (IDLE/DONE -> DONE): DIV/DIVU -> all ones, REM/REMU -> a; latency 1.
REQ-020 Signed overflow (a = -2^(XLEN-1), b = -1) SHALL bypass CALC: DIV -> a, REM -> 0; latency 1.
REQ-021 Multiply by zero operand SHALL NOT bypass; latency fixed per REQ-016.
REQ-022 start while ready=0 SHALL be ignored, no queuing.
REQ-023 abort SHALL force IDLE next cycle from any state, no valid pulse, result unchanged; abort has priority over start the same cycle.
REQ-024 Internal arithmetic SHALL use XLEN+1-bit signed partials for MULHSU/signed cases; sign correction applied once, in transition to DONE.

Reset
REQ-025 reset SHALL force IDLE, counter 0, valid=0, ready=1, result=0, operand registers 0, next cycle.
REQ-026 reset mid-CALC SHALL discard the operation with no valid pulse; reset has priority over abort and start.

Structure
REQ-027 md_op_t (MD_MUL=000, MD_MULH=001, MD_MULHSU=010, MD_MULHU=011, MD_DIV=100, MD_DIVU=101, MD_REM=110, MD_REMU=111) SHALL live in decoder_pkg alongside mul_op_t, which it supersedes.
REQ-028 md_state_t (IDLE/CALC/DONE) SHALL live in decoder_pkg; iteration count width SHALL be $clog2(XLEN/BITS_PER_CYCLE+1), local.
REQ-029 One sub-module, muldiv_step: combinational BITS_PER_CYCLE-bit shift-add / restoring-subtract step, instantiated once.

Verification
REQ-030 op=MULH, a=0xFFFFFFFF, b=0xFFFFFFFF -> valid 33 cycles after accept, result 0x00000000; MULHU same operands -> 0xFFFFFFFE.
REQ-031 op=DIV, a=-7, b=2 -> result 0xFFFFFFFD (-3); op=REM -> 0xFFFFFFFF (-1).
REQ-032 op=DIVU, b=0, a=0x1234 -> valid 1 cycle after accept, result 0xFFFFFFFF; op=REM, a=0x80000000, b=0xFFFFFFFF -> 1 cycle, result 0.
REQ-033 start held high during DONE after MUL 6*7 -> valid with 42, new operation accepted same cycle, ready low next cycle; start during CALC ignored.
REQ-034 abort asserted at iteration 10 of DIVU 100/7 -> IDLE next cycle, no valid, result keeps prior value; reset mid-CALC likewise, result 0.
REQ-035 BITS_PER_CYCLE=4, MULHSU a=0x80000000, b=0x00000002 -> result 0xFFFFFFFF after 9 cycles.
